// File: rtl/line_buffer_n.sv
// Sliding vertical window over LINES raster rows; taps are registered one cycle after each accepted pixel.
// No backpressure: every pix_valid pixel is consumed, idle cycles hold position and emit BOUND_VAL.
module line_buffer_n #(
    parameter int              WIDTH     = 15,
    parameter int              LENGTH    = 1024,
    parameter int              LINES     = 3,
    parameter logic [WIDTH-1:0] BOUND_VAL = WIDTH'(15'b000001000000000)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_valid,
    input  logic                        sof,
    input  logic [WIDTH-1:0]            pix_in,
    output logic [LINES*WIDTH-1:0]      taps,
    output logic                        taps_valid,
    output logic [$clog2(LENGTH)-1:0]   taps_col,
    output logic                        window_ready
);
    localparam int AW = $clog2(LENGTH);
    localparam int FW = $clog2(LINES);

    logic [AW-1:0]    r_col;
    logic [FW-1:0]    r_fill;
    logic [AW-1:0]    w_addr;
    logic [AW-1:0]    w_col_nxt;
    logic [FW-1:0]    w_fill;
    logic [FW-1:0]    w_fill_nxt;
    logic             w_we;
    logic [WIDTH-1:0] w_rd  [LINES];
    logic [WIDTH-1:0] r_dat [LINES];
    logic [LINES-1:0] r_sel;

    // A start-of-frame pixel is column 0 of an empty window, regardless of where the counters were.
    always_comb begin
        w_addr     = (pix_valid && sof) ? '0 : r_col;
        w_fill     = (pix_valid && sof) ? '0 : r_fill;
        w_we       = pix_valid && !rst;
        w_col_nxt  = (w_addr == AW'(LENGTH - 1)) ? '0 : w_addr + 1'b1;
        w_fill_nxt = w_fill;
        if (w_addr == AW'(LENGTH - 1) && w_fill != FW'(LINES - 1)) begin
            w_fill_nxt = w_fill + 1'b1;
        end
    end

    // Row 0 is the incoming pixel; row k comes from line memory k at the same column.
    assign w_rd[0] = pix_in;

    for (genvar k = 1; k < LINES; k++) begin : g_line
        logic [WIDTH-1:0] r_mem [LENGTH];

        assign w_rd[k] = r_mem[w_addr];

        always_ff @(posedge clk) begin
            if (w_we) begin
                r_mem[w_addr] <= w_rd[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            for (int k = 0; k < LINES; k++) begin
                r_dat[k] <= w_rd[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_fill       <= '0;
            r_sel        <= '0;
            taps_valid   <= 1'b0;
            taps_col     <= '0;
            window_ready <= 1'b0;
        end else if (pix_valid) begin
            r_col        <= w_col_nxt;
            r_fill       <= w_fill_nxt;
            window_ready <= (w_fill_nxt == FW'(LINES - 1));
            taps_valid   <= 1'b1;
            taps_col     <= w_addr;
            // Rows not yet written this frame stay masked so stale or undefined memory never escapes.
            for (int k = 0; k < LINES; k++) begin
                r_sel[k] <= (int'(w_fill) >= k);
            end
        end else begin
            taps_valid   <= 1'b0;
            r_sel        <= '0;
        end
    end

    always_comb begin
        taps = '0;
        for (int k = 0; k < LINES; k++) begin
            taps[k*WIDTH +: WIDTH] = r_sel[k] ? r_dat[k] : BOUND_VAL;
        end
    end
endmodule

// File: tb/tb_line_buffer_n.sv
// Self-checking bench: two configurations against a pixel-history model, plus directed literal checks.
module tb_line_buffer_n;
    localparam int LA = 4;
    localparam int NA = 3;
    localparam int WA = 15;
    localparam int BA = 15'h0200;
    localparam int LB = 5;
    localparam int NB = 4;
    localparam int WB = 8;
    localparam int BB = 8'h40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a = 1'b1, pv_a = 1'b0, sof_a = 1'b0;
    logic [WA-1:0]     pix_a = '0;
    logic [NA*WA-1:0]  taps_a;
    logic              tv_a, rdy_a;
    logic [1:0]        tcol_a;

    logic              rst_b = 1'b1, pv_b = 1'b0, sof_b = 1'b0;
    logic [WB-1:0]     pix_b = '0;
    logic [NB*WB-1:0]  taps_b;
    logic              tv_b, rdy_b;
    logic [2:0]        tcol_b;

    line_buffer_n #(.WIDTH(WA), .LENGTH(LA), .LINES(NA)) dut_a (
        .clk(clk), .rst(rst_a), .pix_valid(pv_a), .sof(sof_a), .pix_in(pix_a),
        .taps(taps_a), .taps_valid(tv_a), .taps_col(tcol_a), .window_ready(rdy_a));

    line_buffer_n #(.WIDTH(WB), .LENGTH(LB), .LINES(NB), .BOUND_VAL(8'h40)) dut_b (
        .clk(clk), .rst(rst_b), .pix_valid(pv_b), .sof(sof_b), .pix_in(pix_b),
        .taps(taps_b), .taps_valid(tv_b), .taps_col(tcol_b), .window_ready(rdy_b));

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int sl_a(input int k);
        return int'(taps_a[k*WA +: WA]);
    endfunction

    function automatic int sl_b(input int k);
        return int'(taps_b[k*WB +: WB]);
    endfunction

    // Model: every pixel since the last sof/reset, indexed by arrival order.
    // Pixel n sits at column n%L; row-age k holds pixel n-k*L once that many lines exist.
    int hist_a[$];
    int exp_a[NA];
    int expv_a = 0, expcol_a = 0, exprdy_a = 0;
    int hist_b[$];
    int exp_b[NB];
    int expv_b = 0, expcol_b = 0, exprdy_b = 0;

    initial forever begin
        int n;
        @(posedge clk);
        if (rst_a) begin
            hist_a.delete();
            expv_a = 0; expcol_a = 0; exprdy_a = 0;
            for (int k = 0; k < NA; k++) exp_a[k] = BA;
        end else if (pv_a) begin
            if (sof_a) hist_a.delete();
            hist_a.push_back(int'(pix_a));
            n = hist_a.size() - 1;
            expv_a = 1;
            expcol_a = n % LA;
            exprdy_a = ((n + 1) / LA >= NA - 1) ? 1 : 0;
            for (int k = 0; k < NA; k++) exp_a[k] = (n / LA >= k) ? hist_a[n - k*LA] : BA;
        end else begin
            expv_a = 0;
            for (int k = 0; k < NA; k++) exp_a[k] = BA;
        end
    end

    initial forever begin
        int n;
        @(posedge clk);
        if (rst_b) begin
            hist_b.delete();
            expv_b = 0; expcol_b = 0; exprdy_b = 0;
            for (int k = 0; k < NB; k++) exp_b[k] = BB;
        end else if (pv_b) begin
            if (sof_b) hist_b.delete();
            hist_b.push_back(int'(pix_b));
            n = hist_b.size() - 1;
            expv_b = 1;
            expcol_b = n % LB;
            exprdy_b = ((n + 1) / LB >= NB - 1) ? 1 : 0;
            for (int k = 0; k < NB; k++) exp_b[k] = (n / LB >= k) ? hist_b[n - k*LB] : BB;
        end else begin
            expv_b = 0;
            for (int k = 0; k < NB; k++) exp_b[k] = BB;
        end
    end

    // Compare both instances against the model every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("a_valid", int'(tv_a), expv_a);
            chk("a_col", int'(tcol_a), expcol_a);
            chk("a_ready", int'(rdy_a), exprdy_a);
            for (int k = 0; k < NA; k++) chk($sformatf("a_tap%0d", k), sl_a(k), exp_a[k]);
            chk("b_valid", int'(tv_b), expv_b);
            chk("b_col", int'(tcol_b), expcol_b);
            chk("b_ready", int'(rdy_b), exprdy_b);
            for (int k = 0; k < NB; k++) chk($sformatf("b_tap%0d", k), sl_b(k), exp_b[k]);
        end
    end

    task automatic step_a(input bit v, input bit s, input bit r, input int p);
        @(negedge clk);
        pv_a = v; sof_a = s; rst_a = r; pix_a = WA'(p);
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input bit v, input bit s, input bit r, input int p);
        @(negedge clk);
        pv_b = v; sof_b = s; rst_b = r; pix_b = WB'(p);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step_a(1'b0, 1'b0, 1'b1, 0);
        chk_on = 1'b1;
        chk("rst_valid", int'(tv_a), 0);
        chk("rst_col", int'(tcol_a), 0);
        chk("rst_ready", int'(rdy_a), 0);
        for (int k = 0; k < NA; k++) chk($sformatf("rst_tap%0d", k), sl_a(k), 15'h0200);
        rst_b = 1'b0;

        // Fill: sof then pixels 1..12
        for (int p = 1; p <= 12; p++) begin
            step_a(1'b1, p == 1, 1'b0, p);
            if (p == 7) chk("fill_rdy_p7", int'(rdy_a), 0);
            if (p == 8) chk("fill_rdy_p8", int'(rdy_a), 1);
            if (p == 9) begin
                chk("fill_p9_s0", sl_a(0), 9);
                chk("fill_p9_s1", sl_a(1), 5);
                chk("fill_p9_s2", sl_a(2), 1);
                chk("model_p9_s2", exp_a[2], 1);
                chk("model_p9_s1", exp_a[1], 5);
            end
        end

        // Blanking
        step_a(1'b0, 1'b0, 1'b0, 0);
        chk("blank_valid", int'(tv_a), 0);
        chk("blank_col_hold", int'(tcol_a), 3);
        for (int k = 0; k < NA; k++) chk($sformatf("blank_tap%0d", k), sl_a(k), 15'b000001000000000);
        chk("nf_rdy_before", int'(rdy_a), 1);

        // New frame
        step_a(1'b1, 1'b1, 1'b0, 100);
        chk("nf_s0", sl_a(0), 100);
        chk("nf_s1", sl_a(1), 15'h0200);
        chk("nf_s2", sl_a(2), 15'h0200);
        chk("nf_col", int'(tcol_a), 0);
        chk("nf_rdy", int'(rdy_a), 0);

        // Stall between pixels 2 and 3
        step_a(1'b1, 1'b1, 1'b0, 1);
        step_a(1'b1, 1'b0, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, 1'b0, 1'b0, 0);
            chk("stall_valid", int'(tv_a), 0);
            chk("stall_s0", sl_a(0), 15'h0200);
        end
        for (int p = 3; p <= 8; p++) begin
            step_a(1'b1, 1'b0, 1'b0, p);
            if (p == 3) chk("stall_p3_col", int'(tcol_a), 2);
            if (p == 6) begin
                chk("stall_p6_s0", sl_a(0), 6);
                chk("stall_p6_s1", sl_a(1), 2);
                chk("stall_p6_s2", sl_a(2), 15'h0200);
            end
        end

        // Reset at column 2 of line 2, with a pixel presented in the same cycle
        step_a(1'b1, 1'b1, 1'b0, 1);
        for (int p = 2; p <= 6; p++) step_a(1'b1, 1'b0, 1'b0, p);
        step_a(1'b1, 1'b0, 1'b1, 7);
        chk("mrst_valid", int'(tv_a), 0);
        chk("mrst_col", int'(tcol_a), 0);
        chk("mrst_rdy", int'(rdy_a), 0);
        chk("mrst_s1", sl_a(1), 15'h0200);
        step_a(1'b1, 1'b0, 1'b0, 50);
        chk("mrst_next_col", int'(tcol_a), 0);
        chk("mrst_next_s0", sl_a(0), 50);
        chk("mrst_next_s1", sl_a(1), 15'h0200);

        // Random traffic on config A
        for (int i = 0; i < 1500; i++) begin
            step_a($urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0,
                   $urandom_range(0, 63) == 0, int'($urandom_range(0, 32767)));
        end
        step_a(1'b0, 1'b0, 1'b0, 0);

        // Config B: LENGTH=5, LINES=4, WIDTH=8
        for (int p = 1; p <= 20; p++) begin
            step_b(1'b1, p == 1, 1'b0, p);
            if (p == 5) chk("b_col_p5", int'(tcol_b), 4);
            if (p == 6) chk("b_col_wrap", int'(tcol_b), 0);
            if (p == 15) chk("b_p15_s3", sl_b(3), 8'h40);
            if (p == 16) begin
                chk("b_p16_s3", sl_b(3), 1);
                chk("b_p16_s2", sl_b(2), 6);
                chk("b_p16_s1", sl_b(1), 11);
                chk("model_b_p16_s3", exp_b[3], 1);
            end
        end
        for (int i = 0; i < 1500; i++) begin
            step_b($urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0,
                   $urandom_range(0, 63) == 0, int'($urandom_range(0, 255)));
        end
        step_b(1'b0, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/line_buffer_n.md
LINE_BUFFER_N -- requirements
Module: line_buffer_n

Interface
REQ-001 SHALL have parameter WIDTH, default 15, pixel data bits.
REQ-002 SHALL have parameter LENGTH, default 1024, pixels per line; any value >= 2, not required to be a power of 2.
REQ-003 SHALL have parameter LINES, default 3, number of vertical taps; any value >= 2.
REQ-004 SHALL have parameter BOUND_VAL, default 15'b000001000000000 (fixed-point 1.0), the value driven for blanking and unfilled rows.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port pix_valid, input, 1, pix_in carries an active pixel this cycle.
REQ-008 SHALL have port sof, input, 1, start of frame, qualified only with pix_valid.
REQ-009 SHALL have port pix_in, input, WIDTH, incoming pixel.
REQ-010 SHALL have port taps, output, LINES*WIDTH, where slice k is row age k: 0 = current line, LINES-1 = oldest.
REQ-011 SHALL have port taps_valid, output, 1, taps hold a pixel column.
REQ-012 SHALL have port taps_col, output, clog2(LENGTH), column index of taps.
REQ-013 SHALL have port window_ready, output, 1, all LINES rows hold real frame data.

Function
REQ-014 SHALL keep column counter col (0..LENGTH-1) and fill counter fill (0..LINES-1).
REQ-015 SHALL advance col by 1 on each pix_valid cycle; col == LENGTH-1 wraps to 0 and increments fill, saturating at LINES-1.
REQ-016 SHALL hold col, fill and memory contents when pix_valid is low, so stalls mid-line are lossless.
REQ-017 SHALL use LINES-1 line memories of LENGTH x WIDTH each, mem_1 to mem_{LINES-1}.
REQ-018 On pix_valid, the current column c SHALL be used as the address.
REQ-019 On pix_valid, mem_k[c] SHALL be read before it is written in the same cycle.
REQ-020 On pix_valid, mem_1[c] SHALL be written with pix_in, and mem_k[c] (k >= 2) with the old mem_{k-1}[c].
REQ-021 SHALL have latency 1: on the edge after a pix_valid cycle, slice 0 = pix_in and slice k = old mem_k[c] if fill >= k, else BOUND_VAL.
REQ-022 On that same edge, taps_valid SHALL be 1 and taps_col SHALL be c.
REQ-023 On the edge after a cycle with pix_valid low, all slices SHALL be BOUND_VAL and taps_valid SHALL be 0; taps_col holds.
REQ-024 pix_valid and sof together SHALL clear fill to 0 and treat the pixel as column 0, so taps_col = 0 and slices 1..LINES-1 = BOUND_VAL.
REQ-025 On pix_valid and sof, col SHALL be set to 1, or wrap to 0 if LENGTH == 1 is not allowed; memories are not cleared.
REQ-026 sof with pix_valid low SHALL be ignored.
REQ-027 window_ready SHALL be a registered version of (fill == LINES-1), updated on the same edge as fill.
REQ-028 A line wrap and sof in the same cycle SHALL give sof priority: fill = 0, not an increment.
REQ-029 Memory writes SHALL be synchronous with no reset, so they infer block RAM; memory contents are undefined until written.
REQ-030 The fill gating in REQ-021 SHALL guarantee that undefined memory is never driven on taps.

Reset
REQ-031 rst high at a clock edge SHALL set col = 0, fill = 0, taps_col = 0, taps_valid = 0, window_ready = 0 and every taps slice = BOUND_VAL.
REQ-032 rst SHALL override pix_valid and sof in the same cycle, with no memory write.
REQ-033 rst asserted mid-line or mid-frame SHALL restart as if power-up: the next pixel is column 0 with unfilled rows at BOUND_VAL.

Verification
REQ-034 The bench SHALL cover fill: LENGTH=4, LINES=3, sof then 12 pixels 1..12 -> at the pixel-9 output, taps = {1, 5, 9} oldest to newest, and window_ready rises one edge after pixel 8 is accepted.
REQ-035 The bench SHALL cover stall: pixels 1..8 with pix_valid low for 3 cycles between pixels 2 and 3 -> taps equal the no-stall case, and the 3 stall outputs are BOUND_VAL with taps_valid 0.
REQ-036 The bench SHALL cover blanking value: pix_valid low -> every slice = 15'b000001000000000 one cycle later.
REQ-037 The bench SHALL cover new frame: after window_ready=1, sof with pixel 100 -> slice 0 = 100, slices 1..2 = BOUND_VAL, taps_col 0, and window_ready falls on that edge.
REQ-038 The bench SHALL cover reset mid-line: rst at column 2 of line 2 -> all outputs at reset values next edge, and the next pixel gives taps_col 0.
REQ-039 The bench SHALL cover non-power-of-2 and wide configs: LENGTH=5, LINES=4, WIDTH=8 -> col wraps 4 to 0, and slice 3 is valid from the first pixel of line 4.
